mem_arbiter_6502: RTL
=====================

# mem_arbiter_6502

Two-requester arbiter sharing the single `spi_sram_master` byte/burst memory port between the `cache_6502` miss/writeback path (port 0) and a second master (port 1, e.g. boot loader or DMA engine). It sits between the requesters and `spi_sram_master` in `spi_cpu_6502`. It holds a grant for the full duration of a burst and forwards the ready/data strobes only to the granted requester. Arbitration is fixed-priority with an anti-starvation counter, or round-robin.

## Interface
- `RR`, 0: 0 = port 0 priority with aging; 1 = round-robin.
- `MAX_WAIT`, 15: cycles port 1 may wait in fixed-priority mode before it is promoted (1..255).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `p0_addr`/`p1_addr`  in  24  byte address of the request.
- `p0_en`/`p1_en`  in  1  request valid; held until the transaction completes.
- `p0_wr`/`p1_wr`  in  1  1 = write.
- `p0_rburst`/`p1_rburst`, `p0_wburst`/`p1_wburst`  in  1  more bytes follow in this transaction.
- `p0_wdata`/`p1_wdata`  in  8  write byte.
- `p0_rdy`/`p1_rdy`  out  1  per-byte completion strobe, granted port only.
- `p0_rdata_load`/`p1_rdata_load`  out  1  gated copy of `mem_rdata_load`.
- `p0_rdata`/`p1_rdata`, `p0_rdata0`/`p1_rdata0`  out  8  broadcast of `mem_rdata` and `mem_rdata0` (ungated).
- `mem_addr` 24, `mem_en`, `mem_wr`, `mem_rburst`, `mem_wburst`, `mem_wdata` 8  out  muxed request toward `spi_sram_master`.
- `mem_rdy`, `mem_rdata_load`, `mem_rdata` 8, `mem_rdata0` 8  in  from `spi_sram_master`.
- `grant`  out  2  one-hot current owner; `2'b00` when idle.

## Operation
- States: IDLE, OWN0, OWN1.
- IDLE: no port is granted.
  - With any `pN_en` high, the winner is registered and the FSM moves to OWNn.
  - Fixed mode: port 0 wins unless `wait_cnt == MAX_WAIT`, in which case port 1 wins.
  - RR mode: the port not served last wins when both request. `last` resets to 1, so port 0 wins first.
- OWNn: all `mem_*` request outputs mirror port n. `mem_en = pn_en`.
  - `mem_rdy` is routed to `pn_rdy`; the other port's `rdy` and `rdata_load` are 0.
- Transaction end: `mem_rdy` high while the owner's active burst flag (`rburst` for reads, `wburst` for writes) is low. The FSM returns to IDLE on the next edge. A grant is never changed mid-burst.
- Owner drops `en` before the end: this is a protocol error. Treat it as an end and go to IDLE the next cycle.
- `wait_cnt` (8 bit, fixed mode only):
  - Increments each cycle `p1_en` is high while port 1 is not granted.
  - Saturates at `MAX_WAIT`.
  - Clears when port 1 is granted.
- Simultaneous `mem_rdy` end and a new request: the new request is arbitrated in IDLE. There is no back-to-back grant without passing through IDLE.

## Timing
- Reset values: state IDLE, `grant = 0`, `mem_en/wr/rburst/wburst = 0`, `mem_addr = 0`, `mem_wdata = 0`, all `pN_rdy/rdata_load = 0`, `wait_cnt = 0`, `last = 1`.
- Reset asserted mid-transaction: `mem_en` drops asynchronously. `spi_sram_master` shares `rst`, so it aborts as well.
- Request-to-`mem_en` latency: 1 cycle. `pN_en` is sampled high in IDLE at edge k, and `mem_en` is high from edge k.
- Minimum idle gap between transactions: 1 cycle (the IDLE cycle).
- `mem_*` request outputs are combinational from the registered `grant` and the owner's inputs. They are 0 while IDLE.
- `pN_rdy` and `pN_rdata_load` are combinational gates of `mem_rdy` and `mem_rdata_load`: zero added latency.
- Data outputs are pure wires.

## Structure
- Package `mem_arb_pkg`: state enum (`ARB_IDLE`, `ARB_OWN0`, `ARB_OWN1`), grant encodings, default `MAX_WAIT`.
- Single module with no sub-modules.
- The FSM, `wait_cnt`, `last` and the grant register are in one `always_ff` with async reset.
- The request mux and strobe gating are in an `always_comb`.

## Test plan
- Single read, port 0 only: `p0_en=1`, `p0_addr=24'h001234`, no burst.
  - `mem_en` high with `mem_addr=24'h001234` one cycle after sampling.
  - One `mem_rdy` yields `p0_rdy=1` and `p1_rdy=0`, then `grant` returns to `00` and state to IDLE.
- 4-byte read burst on port 1 while port 0 requests mid-burst: `grant` stays `10` until the 4th `mem_rdy` arrives with `p1_rburst=0`.
  - Port 0 is granted only after one IDLE cycle.
  - `p0_rdy` and `p0_rdata_load` stay 0 throughout the burst.
- Fixed mode, `MAX_WAIT=3`, port 0 issues continuous single writes while `p1_en` is held: port 1 is granted after `wait_cnt` reaches 3, and `wait_cnt` then reads 0.
- RR mode, both ports request continuously with single reads: grants alternate `01`, `10`, `01`, …, starting with port 0 after reset.
- `rst` pulsed during OWN0 mid-wburst: `mem_en`, `mem_wburst` and `grant` go to 0 asynchronously before the next edge.
  - After release, the pending `p1_en` is granted normally.
- Owner drops `p0_en` mid-burst without a final `mem_rdy`: the FSM returns to IDLE next cycle, and port 1's pending request is then granted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port SPI SRAM memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W           = 24;
  localparam int unsigned DATA_W           = 8;
  localparam int unsigned WAIT_W           = 8;
  localparam int unsigned DEFAULT_MAX_WAIT = 15;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_P0   = 2'b01;
  localparam logic [1:0] GRANT_P1   = 2'b10;

  // One requester's view of the memory port.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              en;
    logic              wr;
    logic              rburst;
    logic              wburst;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_6502.sv
// Shares the spi_sram_master port between the cache path (port 0) and a second master (port 1),
// holding each grant for a whole burst and always passing through IDLE between owners.
module mem_arbiter_6502
  import mem_arb_pkg::*;
#(
  parameter bit          RR       = 1'b0,
  parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic              p0_en,
  input  logic              p0_wr,
  input  logic              p0_rburst,
  input  logic              p0_wburst,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_rdy,
  output logic              p0_rdata_load,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p0_rdata0,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              p1_en,
  input  logic              p1_wr,
  input  logic              p1_rburst,
  input  logic              p1_wburst,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_rdy,
  output logic              p1_rdata_load,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [DATA_W-1:0] p1_rdata0,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_wr,
  output logic              mem_rburst,
  output logic              mem_wburst,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rdy,
  input  logic              mem_rdata_load,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] mem_rdata0,
  output logic [1:0]        grant
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_V = WAIT_W'(MAX_WAIT);

  arb_state_t        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              last;
  mem_req_t          req0;
  mem_req_t          req1;
  mem_req_t          sel;
  logic              xfer_end;
  logic              p1_wins;

  // Request mux and strobe gating, driven from the registered grant.
  always_comb begin
    req0 = '{addr: p0_addr, en: p0_en, wr: p0_wr, rburst: p0_rburst,
             wburst: p0_wburst, wdata: p0_wdata};
    req1 = '{addr: p1_addr, en: p1_en, wr: p1_wr, rburst: p1_rburst,
             wburst: p1_wburst, wdata: p1_wdata};
    sel           = '0;
    p0_rdy        = 1'b0;
    p0_rdata_load = 1'b0;
    p1_rdy        = 1'b0;
    p1_rdata_load = 1'b0;
    case (grant)
      GRANT_P0: begin
        sel           = req0;
        p0_rdy        = mem_rdy;
        p0_rdata_load = mem_rdata_load;
      end
      GRANT_P1: begin
        sel           = req1;
        p1_rdy        = mem_rdy;
        p1_rdata_load = mem_rdata_load;
      end
      default: ;
    endcase
  end

  assign mem_addr   = sel.addr;
  assign mem_en     = sel.en;
  assign mem_wr     = sel.wr;
  assign mem_rburst = sel.rburst;
  assign mem_wburst = sel.wburst;
  assign mem_wdata  = sel.wdata;

  assign p0_rdata  = mem_rdata;
  assign p0_rdata0 = mem_rdata0;
  assign p1_rdata  = mem_rdata;
  assign p1_rdata0 = mem_rdata0;

  // Transaction ends on the last byte, or early if the owner abandons its request.
  always_comb begin
    xfer_end = (grant != GRANT_NONE) &&
               (!sel.en || (mem_rdy && !(sel.wr ? sel.wburst : sel.rburst)));
    if (RR) p1_wins = p1_en && (!p0_en || !last);
    else    p1_wins = p1_en && (!p0_en || (wait_cnt == MAX_WAIT_V));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_IDLE;
      grant    <= GRANT_NONE;
      wait_cnt <= '0;
      last     <= 1'b1;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (p1_wins) begin
            state <= ARB_OWN1;
            grant <= GRANT_P1;
            last  <= 1'b1;
          end else if (p0_en) begin
            state <= ARB_OWN0;
            grant <= GRANT_P0;
            last  <= 1'b0;
          end
        end
        ARB_OWN0, ARB_OWN1: begin
          if (xfer_end) begin
            state <= ARB_IDLE;
            grant <= GRANT_NONE;
          end
        end
        default: begin
          state <= ARB_IDLE;
          grant <= GRANT_NONE;
        end
      endcase

      // Aging counter only matters in fixed-priority mode.
      if (RR || (state == ARB_IDLE && p1_wins)) begin
        wait_cnt <= '0;
      end else if (p1_en && state != ARB_OWN1 && wait_cnt != MAX_WAIT_V) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

endmodule
